// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32I load/store funct3 codes,
// the FSM state encoding, the latched-request record and a small address
// helper used by both the top level and the alignment logic.
// -----------------------------------------------------------------------------
package lsu_pkg;

   // RV32I width/sign codes carried in funct3 of LOAD/STORE instructions
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Request fields held for the life of one transaction. Only the byte-lane
   // bits of the address are kept; the word address is registered straight
   // into mem_addr at accept.
   typedef struct packed {
      logic        is_store;
      logic [2:0]  funct3;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } lsu_req_t;

   // Word-aligned form of a byte address
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational data-path helper for the load/store unit.
//   is_store    : 1 = store request, 0 = load request
//   funct3      : RV32I width/sign code
//   addr        : low two bits of the byte address (lane select)
//   word_in     : full word read from memory
//   wdata       : store data from the core
//   load_data   : extracted and sign/zero-extended load result
//   merged_word : word to write back (SW data, or read word with lane replaced)
//   misaligned  : address not naturally aligned for the access width
//   illegal     : funct3 not a legal code for this access direction
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Little-endian lane selection: byte lane by addr[1:0], halfword by addr[1]
   always_comb begin
      byte_lane = word_in[7:0];
      case (addr)
         2'b00:   byte_lane = word_in[7:0];
         2'b01:   byte_lane = word_in[15:8];
         2'b10:   byte_lane = word_in[23:16];
         default: byte_lane = word_in[31:24];
      endcase
      half_lane = addr[1] ? word_in[31:16] : word_in[15:0];
   end

   // Load extraction with sign or zero extension
   always_comb begin
      load_data = 32'h0;
      case (funct3)
         F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   load_data = {24'h0, byte_lane};
         F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
         F3_HU:   load_data = {16'h0, half_lane};
         F3_W:    load_data = word_in;
         default: load_data = 32'h0;
      endcase
   end

   // Store merge: the selected lane comes from wdata, every other byte keeps
   // the value just read from memory
   always_comb begin
      merged_word = word_in;
      case (funct3)
         F3_B: begin
            case (addr)
               2'b00:   merged_word[7:0]   = wdata[7:0];
               2'b01:   merged_word[15:8]  = wdata[7:0];
               2'b10:   merged_word[23:16] = wdata[7:0];
               default: merged_word[31:24] = wdata[7:0];
            endcase
         end
         F3_H: begin
            if (addr[1])
               merged_word[31:16] = wdata[15:0];
            else
               merged_word[15:0] = wdata[15:0];
         end
         F3_W:    merged_word = wdata;
         default: merged_word = word_in;
      endcase
   end

   // Legality and alignment. Unsigned widths exist only for loads.
   always_comb begin
      if (is_store)
         illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

      misaligned = 1'b0;
      case (funct3)
         F3_H, F3_HU: misaligned = addr[0];
         F3_W:        misaligned = (addr != 2'b00);
         default:     misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Accepts one RV32I load/store
// at a time, issues word-aligned accesses to a little-endian byte-addressed
// memory (combinational read, synchronous write), extracts sub-word loads and
// performs read-modify-write for SB/SH. Faulting requests never touch memory.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : core request (valid/ready handshake)
//   resp_*            : one-cycle response pulse with error flag and data
//   mem_addr          : word-aligned memory address
//   mem_write_value   : word to write
//   mem_write_enable  : write strobe
//   mem_read_enable   : read strobe
//   mem_read_value    : combinational read data
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH = 1024
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_value,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_value
);

   localparam logic [32:0] DEPTH_LIMIT = 33'(DEPTH);

   logic [1:0]  state;
   lsu_req_t    req_q;

   logic        sel_is_store;
   logic [2:0]  sel_funct3;
   logic [1:0]  sel_lane;
   logic [31:0] sel_wdata;
   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        misaligned;
   logic        illegal;
   logic        out_of_range;
   logic        accept_err;
   logic        needs_read;

   assign req_ready = (state == ST_IDLE);

   // The alignment helper checks the incoming request while idle and works
   // on the latched request once a transaction is under way
   always_comb begin
      if (state == ST_IDLE) begin
         sel_is_store = req_is_store;
         sel_funct3   = req_funct3;
         sel_lane     = req_addr[1:0];
         sel_wdata    = req_wdata;
      end else begin
         sel_is_store = req_q.is_store;
         sel_funct3   = req_q.funct3;
         sel_lane     = req_q.lane;
         sel_wdata    = req_q.wdata;
      end
   end

   lsu_align u_align (
      .is_store    (sel_is_store),
      .funct3      (sel_funct3),
      .addr        (sel_lane),
      .word_in     (mem_read_value),
      .wdata       (sel_wdata),
      .load_data   (load_data),
      .merged_word (merged_word),
      .misaligned  (misaligned),
      .illegal     (illegal)
   );

   // Range check in 33 bits so addresses near 0xFFFFFFFF cannot wrap past it
   always_comb begin
      out_of_range = ({1'b0, word_align(req_addr)} + 33'd3) >= DEPTH_LIMIT;
      accept_err   = illegal | misaligned | out_of_range;
      // Everything except a full-word store needs the current word first
      needs_read   = !(req_is_store && (req_funct3 == F3_W));
   end

   // Transaction FSM. Every output is registered on the edge that enters the
   // state it belongs to, so strobes are glitch-free and mem_addr /
   // mem_write_value simply hold once the strobes drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         req_q            <= '0;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_rdata       <= 32'h0;
         mem_addr         <= 32'h0;
         mem_write_value  <= 32'h0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q.is_store <= req_is_store;
                  req_q.funct3   <= req_funct3;
                  req_q.lane     <= req_addr[1:0];
                  req_q.wdata    <= req_wdata;
                  if (accept_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else if (needs_read) begin
                     state           <= ST_RD;
                     mem_read_enable <= 1'b1;
                     mem_addr        <= word_align(req_addr);
                  end else begin
                     state            <= ST_WR;
                     mem_write_enable <= 1'b1;
                     mem_addr         <= word_align(req_addr);
                     mem_write_value  <= req_wdata;
                  end
               end
            end

            // Read data is valid this cycle; it is consumed directly into
            // either the load result or the merged write word
            ST_RD: begin
               mem_read_enable <= 1'b0;
               if (req_q.is_store) begin
                  state            <= ST_WR;
                  mem_write_enable <= 1'b1;
                  mem_write_value  <= merged_word;
               end else begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end
            end

            ST_WR: begin
               mem_write_enable <= 1'b0;
               state            <= ST_RESP;
               resp_valid       <= 1'b1;
               resp_err         <= 1'b0;
               resp_rdata       <= 32'h0;
            end

            default: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a word-array memory model.
// Expected responses are queued when a request is issued; a monitor process
// pops and compares them whenever resp_valid is seen, and also checks the
// memory-strobe invariants every cycle.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   typedef struct {
      int          id;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          rd;
      int          wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_value;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [31:0] mem_read_value;

   logic [31:0] mem [0:255];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = 8'h0;
   logic [31:0] pre_data = 32'h0;

   int   cycle_count = 0;
   int   total_checks = 0;
   int   pass_checks = 0;
   int   txn_id = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   load_store_unit #(.DEPTH(1024)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_is_store     (req_is_store),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_err         (resp_err),
      .resp_rdata       (resp_rdata),
      .mem_addr         (mem_addr),
      .mem_write_value  (mem_write_value),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_read_value   (mem_read_value)
   );

   // Memory model: combinational read, synchronous write, plus a preload port
   assign mem_read_value = (mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_data;
      else if (mem_write_enable && (mem_addr < 32'd1024))
         mem[mem_addr[9:2]] <= mem_write_value;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total_checks++;
      if (actual === expected)
         pass_checks++;
      else
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
   endtask

   task automatic preloadWord(input logic [31:0] addr, input logic [31:0] data);
      pre_en   = 1'b1;
      pre_idx  = addr[9:2];
      pre_data = data;
      @(posedge clk);
      #1;
      pre_en = 1'b0;
   endtask

   // Issue one request; called at posedge+1, returns at posedge+1 after the
   // accepting edge with acc set to that edge's cycle number
   task automatic applyStimulus(input logic is_store, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input int exp_lat, input int exp_rd, input int exp_wr,
                                input bit keep, output int acc);
      exp_t e;
      bit   got;
      e.id    = txn_id;
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.lat   = exp_lat;
      e.rd    = exp_rd;
      e.wr    = exp_wr;
      txn_id++;
      exp_q.push_back(e);
      req_is_store = is_store;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_back());
         req_valid = 1'b0;
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc = cycle_count;
         if (!keep) req_valid = 1'b0;
      end
   endtask

   // Wait (bounded) until every queued response has been seen
   task automatic waitDone();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         checkOutput("resp_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: invariants every cycle, scoreboard compare on each response.
   // Latency counts edges from the accepting edge to the edge at which the
   // core samples resp_valid high.
   initial begin
      int   acc_cycle;
      int   rd_cnt;
      int   wr_cnt;
      exp_t e;
      acc_cycle = 0;
      rd_cnt    = 0;
      wr_cnt    = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            assert (!(mem_read_enable && mem_write_enable))
               else checkOutput("rd_wr_exclusive", 32'd1, 32'd0);
            if (mem_read_enable || mem_write_enable)
               checkOutput("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'd0);
            if (req_ready || resp_valid)
               checkOutput("enables_low_idle_resp",
                           {30'h0, mem_read_enable, mem_write_enable}, 32'd0);
            if (mem_read_enable) rd_cnt++;
            if (mem_write_enable) wr_cnt++;
            if (resp_valid) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_resp", {31'h0, resp_valid}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput($sformatf("txn%0d_err", e.id), {31'h0, resp_err}, {31'h0, e.err});
                  checkOutput($sformatf("txn%0d_rdata", e.id), resp_rdata, e.rdata);
                  checkOutput($sformatf("txn%0d_latency", e.id),
                              32'(cycle_count + 1 - acc_cycle), 32'(e.lat));
                  checkOutput($sformatf("txn%0d_read_cycles", e.id), 32'(rd_cnt), 32'(e.rd));
                  checkOutput($sformatf("txn%0d_write_cycles", e.id), 32'(wr_cnt), 32'(e.wr));
               end
            end
            if (req_valid && req_ready) begin
               acc_cycle = cycle_count + 1;
               rd_cnt    = 0;
               wr_cnt    = 0;
            end
         end
      end
   end

   initial begin
      int  a1;
      int  a2;
      int  a3;
      bit  hit;
      repeat (2) @(posedge clk);
      #1;
      preloadWord(32'h10, 32'h8899AABB);
      preloadWord(32'h30, 32'hAABBCCDD);
      preloadWord(32'h40, 32'hCAFEF00D);
      preloadWord(32'h50, 32'h11223344);
      preloadWord(32'h3FC, 32'h01020304);

      // Reset state
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
      checkOutput("rst_resp_err", {31'h0, resp_err}, 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_write_value", mem_write_value, 32'h0);
      rst = 1'b0;

      // Loads from word 0x10 = 0x8899AABB
      applyStimulus(0, 3'b000, 32'h12, 32'h0, 0, 32'hFFFFFF99, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b100, 32'h12, 32'h0, 0, 32'h00000099, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF8899, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'h8899AABB, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b101, 32'h10, 32'h0, 0, 32'h0000AABB, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b000, 32'h11, 32'h0, 0, 32'hFFFFFFAA, 2, 1, 0, 0, a1); waitDone();

      // Full-word store then read back
      applyStimulus(1, 3'b010, 32'h20, 32'h12345678, 0, 32'h0, 2, 0, 1, 0, a1); waitDone();
      checkOutput("mem_0x20_after_sw", mem[8'h08], 32'h12345678);
      applyStimulus(0, 3'b010, 32'h20, 32'h0, 0, 32'h12345678, 2, 1, 0, 0, a1); waitDone();

      // Sub-word read-modify-write on word 0x30 = 0xAABBCCDD
      applyStimulus(1, 3'b000, 32'h31, 32'h000000EE, 0, 32'h0, 3, 1, 1, 0, a1); waitDone();
      checkOutput("mem_0x30_after_sb", mem[8'h0C], 32'hAABBEEDD);
      applyStimulus(1, 3'b001, 32'h32, 32'hFFFF1234, 0, 32'h0, 3, 1, 1, 0, a1); waitDone();
      checkOutput("mem_0x30_after_sh", mem[8'h0C], 32'h1234EEDD);
      applyStimulus(0, 3'b001, 32'h32, 32'h0, 0, 32'h00001234, 2, 1, 0, 0, a1); waitDone();

      // Faults: misaligned, illegal funct3, out of range
      applyStimulus(0, 3'b010, 32'h22, 32'h0, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(1, 3'b001, 32'h41, 32'h5555, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(1, 3'b100, 32'h10, 32'h77, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b010, 32'h3FE, 32'h0, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b010, 32'h400, 32'h0, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b000, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, 0, 0, 0, a1); waitDone();
      checkOutput("mem_0x40_unchanged", mem[8'h10], 32'hCAFEF00D);
      checkOutput("mem_0x10_unchanged", mem[8'h04], 32'h8899AABB);

      // Highest in-range word
      applyStimulus(0, 3'b010, 32'h3FC, 32'h0, 0, 32'h01020304, 2, 1, 0, 0, a1); waitDone();
      applyStimulus(0, 3'b100, 32'h3FF, 32'h0, 0, 32'h00000001, 2, 1, 0, 0, a1); waitDone();

      // Reset while an SB sits in WR: transaction dropped, no response
      applyStimulus(1, 3'b000, 32'h50, 32'h00000077, 0, 32'h0, 3, 1, 1, 0, a1);
      hit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_write_enable) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput("sb_reached_write", {31'h0, hit}, 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      checkOutput("abort_write_enable", {31'h0, mem_write_enable}, 32'd0);
      checkOutput("abort_read_enable", {31'h0, mem_read_enable}, 32'd0);
      checkOutput("abort_req_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      applyStimulus(0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFBB, 2, 1, 0, 0, a1); waitDone();

      // Back-to-back with req_valid held high
      applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'h8899AABB, 2, 1, 0, 1, a1);
      applyStimulus(1, 3'b010, 32'h60, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, 1, a2);
      applyStimulus(0, 3'b010, 32'h60, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0, 0, a3);
      waitDone();
      checkOutput("b2b_gap_load_to_store", 32'(a2 - a1), 32'd3);
      checkOutput("b2b_gap_store_to_load", 32'(a3 - a2), 32'd3);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Takes one RV32I load or store request at a time from the core (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives word-aligned read or write accesses to the byte-addressed, little-endian data memory. Memory read is combinational; memory write is synchronous.
- Performs byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores. Faults are returned to the core instead of being issued to memory.

Parameters:
- DEPTH, 1024, memory size in bytes. Any access with word address + 3 >= DEPTH is out of range.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request (IDLE only)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned, illegal funct3, or out of range; valid with resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  word-aligned address to memory (low 2 bits always 00)
- mem_write_value  out  32  full word to write
- mem_write_enable  out  1  write strobe
- mem_read_enable  out  1  read strobe
- mem_read_value  in  32  combinational read data

Behaviour:
- Reset (synchronous, rst high at clk edge): state=IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_write_value=0. A request in flight is dropped with no response; no enable is asserted on the cycle after reset.
- Accept: req_valid && req_ready in IDLE. Register is_store, funct3, addr, wdata. req_ready=0 in every non-IDLE state.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is an error.
- Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
- Error check is done at accept: illegal funct3, misaligned, or (addr & ~3)+3 >= DEPTH → next state RESP with resp_err=1. No memory enable is asserted for an errored request.
- States: IDLE, RD, WR, RESP.
  - IDLE → RESP on error.
  - IDLE → RD for a load or a sub-word store.
  - IDLE → WR for SW.
  - RD: mem_read_enable=1, mem_addr=addr & ~3. Capture mem_read_value into a word register the same cycle. Load → RESP; sub-word store → WR.
  - WR: mem_write_enable=1, mem_addr=addr & ~3, mem_write_value = SW data or merged word. → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
- Latency in cycles from the accept edge to resp_valid:
  - Error: 1.
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
- The next request can be accepted in the cycle after RESP.
- Load extract: byte lane addr[1:0], halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge: SB replaces byte lane addr[1:0] with wdata[7:0]. SH replaces halfword lane addr[1] with wdata[15:0]. All other bytes come from the captured read word.
- Invariants, checked with assertions in the bench:
  - mem_read_enable and mem_write_enable are never high together.
  - mem_addr[1:0]=00 whenever either enable is high.
  - Enables are 0 in IDLE and RESP.
- Outputs are registered per state; mem_addr and mem_write_value hold their last value when the enables are low.
- req_valid while busy is ignored; the core must hold it until req_ready.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE/RD/WR/RESP.
- Sub-module lsu_align, purely combinational:
  - Inputs: funct3, addr[1:0], word_in, wdata.
  - Outputs: load_data (extended), merged_word (store merge), misaligned, illegal.

Test Plan:
- Preload mem word@0x10 = 0x8899AABB. LB @0x12 → after 2 cycles resp_rdata=0xFFFFFF99, err=0. LBU @0x12 → 0x00000099. LH @0x12 → 0xFFFF8899. LW @0x10 → 0x8899AABB.
- SW 0x12345678 @0x20, then LW @0x20 → 0x12345678. SW response comes 2 cycles after accept, with exactly one write cycle and no read cycle.
- Word@0x30 = 0xAABBCCDD. SB wdata=0x000000EE @0x31 → memory word 0xAABBEEDD. SH wdata=0x1234 @0x32 → 0x1234EEDD. Each response comes 3 cycles after accept, with a read cycle followed by a write cycle.
- Faults, each → resp_err=1 one cycle after accept, no enables ever asserted, memory unchanged:
  - LW @0x22, SH @0x41, funct3=011 load, store funct3=100.
  - LW @0x3FE with DEPTH=1024.
- Assert rst while in WR during an SB → no resp_valid, write enable low from the next cycle, req_ready=1. A following LB is serviced normally.
- Back-to-back requests with req_valid held high → the second is accepted the cycle after the first RESP, and read and write enables are never high together throughout.
